apb_irq_fetcher: RTL and testbench

APB_IRQ_FETCHER -- requirements
Module: apb_irq_fetcher

---
 rtl/apb_irq_fetcher.sv | 117 +++++++++++
 tb/tb_apb_irq_fetcher.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_irq_fetcher.sv
// Fetches interrupt vectors over APB: an active FIQ/IRQ line triggers a status read, whose lowest set bit is presented on a valid/ready port.
// Latency: 3 cycles from line sampled to vec_valid with zero-wait slaves; +1 per PREADY=0 cycle. Backpressure: vec_ready stalls in PRESENT.
module apb_irq_fetcher #(
    parameter logic        IRQPOLARITY = 1'b0,
    parameter logic        FIQPOLARITY = 1'b0,
    parameter int unsigned HOLDOFF     = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        IRQ,
    input  logic        FIQ,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [3:0]  PADDR,
    output logic        PWRITE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        vec_valid,
    input  logic        vec_ready,
    output logic        vec_fiq,
    output logic [4:0]  vec_num,
    output logic [31:0] vec_raw,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, PRESENT, HOLD} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);
    localparam logic [3:0] ADDR_FIQ  = 4'h5;
    localparam logic [3:0] ADDR_IRQ  = 4'hB;

    state_t      state;
    state_t      state_nxt;
    logic        fetch_fiq;
    logic [3:0]  hold_cnt;
    logic        irq_act;
    logic        fiq_act;
    logic [31:0] masked;
    logic        done;
    logic        bad;

    assign irq_act = IRQPOLARITY ? IRQ : ~IRQ;
    assign fiq_act = FIQPOLARITY ? FIQ : ~FIQ;
    assign masked  = fetch_fiq ? {24'h0, PRDATA[7:0]} : PRDATA;
    assign done    = (state == ACCESS) && PREADY;
    assign bad     = PSLVERR || (masked == 32'h0);
    assign PWRITE  = 1'b0;

    function automatic logic [4:0] lsb_index(input logic [31:0] d);
        lsb_index = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) lsb_index = 5'(i);
        end
    endfunction

    always_comb begin
        state_nxt = state;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        vec_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fiq_act || irq_act) state_nxt = SETUP;
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) state_nxt = bad ? HOLD : PRESENT;
            end
            PRESENT: begin
                vec_valid = 1'b1;
                if (vec_ready) state_nxt = HOLD;
            end
            HOLD: begin
                if (hold_cnt == 4'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            fetch_fiq <= 1'b0;
            PADDR     <= 4'h0;
            vec_fiq   <= 1'b0;
            vec_num   <= 5'd0;
            vec_raw   <= 32'h0;
            err_cnt   <= 8'h00;
            hold_cnt  <= HOLD_LOAD;
        end else begin
            // FIQ takes priority when both lines are active in the same cycle
            if (state == IDLE && state_nxt == SETUP) begin
                fetch_fiq <= fiq_act;
                PADDR     <= fiq_act ? ADDR_FIQ : ADDR_IRQ;
            end
            if (done && !bad) begin
                vec_raw <= masked;
                vec_fiq <= fetch_fiq;
                vec_num <= lsb_index(masked);
            end
            if (done && bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (state == HOLD) hold_cnt <= hold_cnt - 4'd1;
            else               hold_cnt <= HOLD_LOAD;
        end
    end

endmodule

// File: tb/tb_apb_irq_fetcher.sv
// Bench for apb_irq_fetcher with default parameters (active-low lines, HOLDOFF=2); the bench plays the APB slave.
module tb_apb_irq_fetcher;

    localparam int HOLDOFF = 2;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        IRQ;
    logic        FIQ;
    logic        PSEL;
    logic        PENABLE;
    logic [3:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        vec_valid;
    logic        vec_ready;
    logic        vec_fiq;
    logic [4:0]  vec_num;
    logic [31:0] vec_raw;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;

    apb_irq_fetcher dut (
        .PCLK(PCLK), .PRESET(PRESET), .IRQ(IRQ), .FIQ(FIQ),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_fiq(vec_fiq),
        .vec_num(vec_num), .vec_raw(vec_raw), .err_cnt(err_cnt)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the vector is the index of the isolated lowest set bit of the masked word.
    function automatic logic [31:0] ref_num(input logic [31:0] m);
        logic [31:0] iso;
        iso = m & (~m + 32'd1);
        return 32'($clog2(iso));
    endfunction

    // Starts at a negedge with the DUT idle; returns in the first HOLD cycle when keep=1,
    // otherwise after the holdoff has elapsed and the DUT is idle again.
    task automatic fetch(input logic f, input logic i, input logic [31:0] data, input int waits,
                         input logic serr, input int rdly, input logic keep);
        logic [31:0] eaddr;
        logic [31:0] m;
        logic [31:0] enum_v;
        logic        err;
        eaddr  = f ? 32'h5 : 32'hB;
        m      = f ? {24'h0, data[7:0]} : data;
        err    = serr || (m == 32'h0);
        enum_v = ref_num(m);
        FIQ = ~f; IRQ = ~i; PRDATA = data; PSLVERR = serr; PREADY = 1'b0; vec_ready = 1'b0;
        @(negedge PCLK);
        check("setup_psel", 32'(PSEL), 32'd1);
        check("setup_penable", 32'(PENABLE), 32'd0);
        check("setup_paddr", 32'(PADDR), eaddr);
        check("setup_valid", 32'(vec_valid), 32'd0);
        if (!keep) begin FIQ = 1'b1; IRQ = 1'b1; end
        for (int j = 0; j <= waits; j++) begin
            @(negedge PCLK);
            check("access_psel", 32'(PSEL), 32'd1);
            check("access_penable", 32'(PENABLE), 32'd1);
            check("access_paddr", 32'(PADDR), eaddr);
            check("access_pwrite", 32'(PWRITE), 32'd0);
            PREADY = (j == waits);
        end
        @(negedge PCLK);
        PREADY = 1'b0;
        check("post_psel", 32'(PSEL), 32'd0);
        check("post_penable", 32'(PENABLE), 32'd0);
        if (err) begin
            if (exp_err < 255) exp_err++;
            check("err_valid", 32'(vec_valid), 32'd0);
            check("err_cnt", 32'(err_cnt), 32'(exp_err));
        end else begin
            check("vec_valid", 32'(vec_valid), 32'd1);
            check("vec_fiq", 32'(vec_fiq), 32'(f));
            check("vec_num", 32'(vec_num), enum_v);
            check("vec_raw", vec_raw, m);
            check("vec_err_cnt", 32'(err_cnt), 32'(exp_err));
            for (int r = 0; r < rdly; r++) begin
                @(negedge PCLK);
                check("stall_valid", 32'(vec_valid), 32'd1);
                check("stall_num", 32'(vec_num), enum_v);
                check("stall_raw", vec_raw, m);
                check("stall_fiq", 32'(vec_fiq), 32'(f));
                check("stall_psel", 32'(PSEL), 32'd0);
            end
            vec_ready = 1'b1;
            @(negedge PCLK);
            vec_ready = 1'b0;
            check("accept_valid", 32'(vec_valid), 32'd0);
        end
        if (!keep) begin
            for (int k = 0; k <= HOLDOFF; k++) begin
                check("hold_psel", 32'(PSEL), 32'd0);
                @(negedge PCLK);
            end
        end
    endtask

    initial begin
        logic [1:0]  sel;
        logic [31:0] data;
        int          gap;

        PRESET = 1'b1; IRQ = 1'b1; FIQ = 1'b1; PRDATA = 32'h0; PREADY = 1'b0;
        PSLVERR = 1'b0; vec_ready = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_valid", 32'(vec_valid), 32'd0);
        check("rst_fiq", 32'(vec_fiq), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_num", 32'(vec_num), 32'd0);
        check("rst_raw", vec_raw, 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        fetch(1'b0, 1'b1, 32'h0000_0140, 0, 1'b0, 0, 1'b0);   // basic IRQ, vec 6
        fetch(1'b1, 1'b1, 32'hFFFF_FF80, 0, 1'b0, 1, 1'b0);   // FIQ wins, masked to 0x80
        fetch(1'b0, 1'b1, 32'h0001_0000, 4, 1'b0, 0, 1'b0);   // 4 wait states
        fetch(1'b0, 1'b1, 32'h0000_0001, 0, 1'b1, 0, 1'b0);   // slave error
        fetch(1'b0, 1'b1, 32'h0000_0000, 1, 1'b0, 0, 1'b0);   // spurious zero read
        fetch(1'b1, 1'b0, 32'hFFFF_FF00, 0, 1'b0, 0, 1'b0);   // FIQ bits masked away
        fetch(1'b0, 1'b1, 32'h8000_0000, 0, 1'b0, 10, 1'b0);  // consumer stalls 10 cycles

        for (int n = 0; n < 24; n++) begin
            sel  = 2'($urandom_range(1, 3));
            data = $urandom;
            if ($urandom_range(0, 7) == 0) data = 32'h0;
            else data = data << $urandom_range(0, 31);
            fetch(sel[1], sel[0], data, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), 1'b0);
        end

        // IRQ held through acceptance: HOLDOFF hold cycles plus the IDLE sampling cycle precede SETUP
        fetch(1'b0, 1'b1, 32'h0000_0C00, 0, 1'b0, 0, 1'b1);
        gap = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (PSEL) break;
            gap++;
        end
        check("holdoff_gap", 32'(gap), 32'(HOLDOFF + 1));
        check("refetch_penable", 32'(PENABLE), 32'd0);
        IRQ = 1'b1; PREADY = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        check("refetch_valid", 32'(vec_valid), 32'd1);
        check("refetch_num", 32'(vec_num), 32'd10);
        vec_ready = 1'b1;
        @(negedge PCLK);
        vec_ready = 1'b0; PREADY = 1'b0;
        repeat (HOLDOFF + 1) @(negedge PCLK);

        for (int n = 0; n < 300; n++) fetch(1'b0, 1'b1, 32'h1, 0, 1'b1, 0, 1'b0);
        check("err_saturated", 32'(err_cnt), 32'hFF);
        fetch(1'b0, 1'b1, 32'h0, 0, 1'b0, 0, 1'b0);

        // Reset in the middle of a stalled ACCESS
        IRQ = 1'b0; PREADY = 1'b0; PRDATA = 32'h8000_0000; PSLVERR = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("mid_psel_before", 32'(PSEL), 32'd1);
        #1 PRESET = 1'b1;
        #1;
        check("mid_psel", 32'(PSEL), 32'd0);
        check("mid_penable", 32'(PENABLE), 32'd0);
        check("mid_valid", 32'(vec_valid), 32'd0);
        check("mid_paddr", 32'(PADDR), 32'd0);
        check("mid_err", 32'(err_cnt), 32'd0);
        exp_err = 0;
        @(negedge PCLK);
        PRESET = 1'b0; PREADY = 1'b1;
        @(negedge PCLK);
        check("fresh_psel", 32'(PSEL), 32'd1);
        check("fresh_penable", 32'(PENABLE), 32'd0);
        check("fresh_paddr", 32'(PADDR), 32'hB);
        IRQ = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        check("fresh_valid", 32'(vec_valid), 32'd1);
        check("fresh_num", 32'(vec_num), 32'd31);
        check("fresh_raw", vec_raw, 32'h8000_0000);
        check("fresh_err", 32'(err_cnt), 32'(exp_err));
        vec_ready = 1'b1;
        @(negedge PCLK);
        vec_ready = 1'b0;
        check("fresh_accept", 32'(vec_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
